// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NREAD registered read ports with
// write-to-read bypass, and a per-register busy scoreboard for decode hazard checks.
module regfile_mp #(
   parameter int DATAWIDTH = 32,
   parameter int ADDRWIDTH = 5,
   parameter int NREAD     = 2,
   parameter int ZERO_REG  = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NREAD*ADDRWIDTH-1:0]   readReg,
   output logic [NREAD*DATAWIDTH-1:0]   readData,
   output logic [NREAD-1:0]             readBusy,
   input  logic                         write0,
   input  logic [ADDRWIDTH-1:0]         writeReg0,
   input  logic [DATAWIDTH-1:0]         writeData0,
   input  logic                         write1,
   input  logic [ADDRWIDTH-1:0]         writeReg1,
   input  logic [DATAWIDTH-1:0]         writeData1,
   input  logic                         reserve,
   input  logic [ADDRWIDTH-1:0]         reserveReg,
   output logic                         anyBusy
);

   localparam int DEPTH = 1 << ADDRWIDTH;

   logic [DATAWIDTH-1:0]       mem_q [DEPTH];
   logic [DATAWIDTH-1:0]       mem_d [DEPTH];
   logic [DEPTH-1:0]           busy_q, busy_d;
   logic [NREAD*DATAWIDTH-1:0] read_data_q, read_data_d;
   logic [NREAD-1:0]           read_busy_q, read_busy_d;
   logic                       any_busy_q, any_busy_d;

   logic zero_on;
   logic wr0_en, wr1_en, res_en;

   assign zero_on = (ZERO_REG != 0);
   assign wr0_en  = write0  && !(zero_on && (writeReg0  == '0));
   assign wr1_en  = write1  && !(zero_on && (writeReg1  == '0));
   assign res_en  = reserve && !(zero_on && (reserveReg == '0));

   // Port 1 is applied last so it wins a same-address collision.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (wr0_en) mem_d[writeReg0] = writeData0;
      if (wr1_en) mem_d[writeReg1] = writeData1;
   end

   // A reserve beats a retiring write: the new producer owns the register.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
      logic hit_res, hit_wr;
      assign hit_res = res_en && (reserveReg == ADDRWIDTH'(gi));
      assign hit_wr  = (write0 && (writeReg0 == ADDRWIDTH'(gi))) ||
                       (write1 && (writeReg1 == ADDRWIDTH'(gi)));
      assign busy_d[gi] = hit_res ? 1'b1 : (hit_wr ? 1'b0 : busy_q[gi]);
   end

   // Reading the post-write image gives bypass and zero-register behaviour for free.
   for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
      logic [ADDRWIDTH-1:0] addr;
      assign addr = readReg[gi*ADDRWIDTH +: ADDRWIDTH];
      assign read_data_d[gi*DATAWIDTH +: DATAWIDTH] = mem_d[addr];
      assign read_busy_d[gi] = busy_d[addr];
   end

   assign any_busy_d = |busy_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         busy_q      <= '0;
         read_data_q <= '0;
         read_busy_q <= '0;
         any_busy_q  <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         busy_q      <= busy_d;
         read_data_q <= read_data_d;
         read_busy_q <= read_busy_d;
         any_busy_q  <= any_busy_d;
      end
   end

   assign readData = read_data_q;
   assign readBusy = read_busy_q;
   assign anyBusy  = any_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default config, ZERO_REG=0 twin sharing the
// same stimulus, and a 4-read-port narrow instance.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rd_reg;
   logic        wr0, wr1, res;
   logic [4:0]  wr_reg0, wr_reg1, res_reg;
   logic [31:0] wr_data0, wr_data1;

   logic [63:0] a_data, b_data;
   logic [1:0]  a_busy, b_busy;
   logic        a_any, b_any;

   logic [11:0] c_rd_reg;
   logic        c_wr0, c_wr1;
   logic [2:0]  c_wr_reg0, c_wr_reg1;
   logic [15:0] c_wr_data0, c_wr_data1;
   logic [63:0] c_data;
   logic [3:0]  c_busy;
   logic        c_any;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   regfile_mp #(.DATAWIDTH(32), .ADDRWIDTH(5), .NREAD(2), .ZERO_REG(1)) dut_a (
      .clk(clk), .rst(rst), .readReg(rd_reg), .readData(a_data), .readBusy(a_busy),
      .write0(wr0), .writeReg0(wr_reg0), .writeData0(wr_data0),
      .write1(wr1), .writeReg1(wr_reg1), .writeData1(wr_data1),
      .reserve(res), .reserveReg(res_reg), .anyBusy(a_any));

   regfile_mp #(.DATAWIDTH(32), .ADDRWIDTH(5), .NREAD(2), .ZERO_REG(0)) dut_b (
      .clk(clk), .rst(rst), .readReg(rd_reg), .readData(b_data), .readBusy(b_busy),
      .write0(wr0), .writeReg0(wr_reg0), .writeData0(wr_data0),
      .write1(wr1), .writeReg1(wr_reg1), .writeData1(wr_data1),
      .reserve(res), .reserveReg(res_reg), .anyBusy(b_any));

   regfile_mp #(.DATAWIDTH(16), .ADDRWIDTH(3), .NREAD(4), .ZERO_REG(1)) dut_c (
      .clk(clk), .rst(rst), .readReg(c_rd_reg), .readData(c_data), .readBusy(c_busy),
      .write0(c_wr0), .writeReg0(c_wr_reg0), .writeData0(c_wr_data0),
      .write1(c_wr1), .writeReg1(c_wr_reg1), .writeData1(c_wr_data1),
      .reserve(1'b0), .reserveReg(3'd0), .anyBusy(c_any));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr0 = 0; wr1 = 0; res = 0;
      wr_reg0 = 0; wr_reg1 = 0; res_reg = 0;
      wr_data0 = 0; wr_data1 = 0;
      c_wr0 = 0; c_wr1 = 0; c_wr_reg0 = 0; c_wr_reg1 = 0;
      c_wr_data0 = 0; c_wr_data1 = 0;
   endtask

   initial begin
      idle();
      rd_reg = 0; c_rd_reg = 0;
      rst = 1;
      step(); step();
      check("reset_any_a", 64'(a_any), 64'd0);

      // 1: reset state
      rst = 0;
      rd_reg = {5'd3, 5'd3};
      step();
      check("t1_data", a_data, 64'd0);
      check("t1_busy", 64'(a_busy), 64'd0);
      check("t1_any", 64'(a_any), 64'd0);

      // 2: bypass then hold
      rd_reg = {5'd3, 5'd5};
      wr0 = 1; wr_reg0 = 5; wr_data0 = 32'hDEADBEEF;
      step();
      check("t2_bypass", 64'(a_data[31:0]), 64'hDEADBEEF);
      idle();
      step();
      check("t2_hold", 64'(a_data[31:0]), 64'hDEADBEEF);

      // 3: port 1 wins
      rd_reg = {5'd7, 5'd7};
      wr0 = 1; wr_reg0 = 7; wr_data0 = 32'h11;
      wr1 = 1; wr_reg1 = 7; wr_data1 = 32'h22;
      step();
      check("t3_bypass", a_data, {32'h22, 32'h22});
      idle();
      step();
      check("t3_stored", a_data, {32'h22, 32'h22});

      // 4: scoreboard
      rd_reg = {5'd3, 5'd9};
      res = 1; res_reg = 9;
      step();
      idle();
      step();
      check("t4_busy", 64'(a_busy[0]), 64'd1);
      check("t4_any", 64'(a_any), 64'd1);
      wr1 = 1; wr_reg1 = 9; wr_data1 = 32'h5;
      step();
      check("t4_wr_data", 64'(a_data[31:0]), 64'h5);
      check("t4_wr_busy", 64'(a_busy[0]), 64'd0);
      check("t4_wr_any", 64'(a_any), 64'd0);
      idle();
      res = 1; res_reg = 9;
      wr0 = 1; wr_reg0 = 9; wr_data0 = 32'h6;
      step();
      check("t4_rw_busy", 64'(a_busy[0]), 64'd1);
      check("t4_rw_data", 64'(a_data[31:0]), 64'h6);
      idle();
      step();
      check("t4_rw_hold", 64'(a_busy[0]), 64'd1);
      wr0 = 1; wr_reg0 = 9; wr_data0 = 32'h6;
      step();
      idle();
      check("t4_clear_any", 64'(a_any), 64'd0);

      // 5: zero register
      rd_reg = {5'd0, 5'd0};
      wr0 = 1; wr_reg0 = 0; wr_data0 = 32'hFFFF;
      res = 1; res_reg = 0;
      step();
      idle();
      check("t5_a_data", a_data, 64'd0);
      check("t5_a_busy", 64'(a_busy), 64'd0);
      check("t5_a_any", 64'(a_any), 64'd0);
      check("t5_b_data", b_data, {32'hFFFF, 32'hFFFF});
      check("t5_b_busy", 64'(b_busy), 64'd3);
      check("t5_b_any", 64'(b_any), 64'd1);
      step();
      check("t5_a_hold", a_data, 64'd0);
      check("t5_b_hold", b_data, {32'hFFFF, 32'hFFFF});

      // 6: reset discards writes and reservations
      wr0 = 1; wr_reg0 = 1; wr_data0 = 32'hA;
      res = 1; res_reg = 2;
      step();
      idle();
      rd_reg = {5'd2, 5'd1};
      step();
      check("t6_pre_data", 64'(a_data[31:0]), 64'hA);
      check("t6_pre_busy", 64'(a_busy), 64'd2);
      rst = 1;
      wr0 = 1; wr_reg0 = 1; wr_data0 = 32'hB;
      step();
      check("t6_rst_data", a_data, 64'd0);
      check("t6_rst_busy", 64'(a_busy), 64'd0);
      check("t6_rst_any_b", 64'(b_any), 64'd0);
      rst = 0;
      idle();
      step();
      check("t6_post_data", a_data, 64'd0);
      check("t6_post_busy", 64'(a_busy), 64'd0);
      check("t6_post_any", 64'(a_any), 64'd0);

      // 6b: four read ports
      c_wr0 = 1; c_wr_reg0 = 1; c_wr_data0 = 16'd1;
      c_wr1 = 1; c_wr_reg1 = 2; c_wr_data1 = 16'd2;
      step();
      c_wr_reg0 = 3; c_wr_data0 = 16'd3;
      c_wr_reg1 = 4; c_wr_data1 = 16'd4;
      step();
      idle();
      c_rd_reg = {3'd4, 3'd3, 3'd2, 3'd1};
      step();
      check("t6_c_data", c_data, {16'd4, 16'd3, 16'd2, 16'd1});
      check("t6_c_busy", 64'(c_busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
